// File: rtl/channel_mux_fifo_if.sv
// Bundled producer/consumer signals for channel_mux_fifo: N_CH input channels
// merged onto one output channel, with latency feedback in both directions.
interface channel_mux_fifo_if #(
  parameter int N_CH                = 4,
  parameter int N                   = 10,
  parameter int LATENCY_COUNT_WIDTH = 6
);
  logic [N_CH-1:0]                     in_valid;
  logic [N_CH*N-1:0]                   in_data;
  logic [N_CH-1:0]                     in_ready;
  logic [N_CH*LATENCY_COUNT_WIDTH-1:0] in_latency;
  logic                                out_valid;
  logic [N-1:0]                        out_data;
  logic [$clog2(N_CH)-1:0]             out_chan;
  logic                                out_ready;
  logic [LATENCY_COUNT_WIDTH-1:0]      out_latency;

  modport master (
    output in_valid, in_data, out_ready, out_latency,
    input  in_ready, in_latency, out_valid, out_data, out_chan
  );

  modport slave (
    input  in_valid, in_data, out_ready, out_latency,
    output in_ready, in_latency, out_valid, out_data, out_chan
  );
endinterface

// File: rtl/channel_mux_fifo.sv
// Per-channel FIFOs merged onto one output by a round-robin or fixed-priority
// arbiter that locks its grant while the consumer stalls.
module channel_mux_fifo #(
  parameter int N_CH                = 4,
  parameter int N                   = 10,
  parameter int DEPTH               = 4,
  parameter int LATENCY_COUNT_WIDTH = 6,
  parameter int ARB_MODE            = 0
) (
  input logic               clk,
  input logic               rst,
  channel_mux_fifo_if.slave bus
);
  localparam int CW   = $clog2(N_CH);
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;
  localparam int LW   = LATENCY_COUNT_WIDTH;
  localparam int SW   = LW + 2;
  localparam logic [SW-1:0] LAT_MAX = SW'((1 << LW) - 1);

  typedef enum logic {IDLE, LOCKED} arb_state_t;

  arb_state_t state, state_next;

  logic [N-1:0]    mem [N_CH][DEPTH];
  logic [PW-1:0]   wr_ptr [N_CH];
  logic [PW-1:0]   rd_ptr [N_CH];
  logic [CNTW-1:0] count  [N_CH];

  logic [N_CH-1:0]    ready, push, pop, nonempty;
  logic [CW-1:0]      grant, rr_grant, fp_grant, lock_grant, last_grant, idx;
  logic               rr_found, fp_found, valid, fire;
  logic [N-1:0]       head, hold_data;
  logic [CW-1:0]      hold_chan;
  logic [SW-1:0]      lat_sum;
  logic [N_CH*LW-1:0] lat_vec;

  // Ready is forced low while reset is held so no word is taken during reset.
  always_comb begin
    ready    = '0;
    nonempty = '0;
    push     = '0;
    pop      = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      nonempty[i] = (count[i] != '0);
      ready[i]    = !rst && (count[i] != CNTW'(DEPTH));
      push[i]     = bus.in_valid[i] && ready[i];
      pop[i]      = fire && (grant == CW'(i));
    end
  end

  always_comb begin
    rr_grant = last_grant;
    rr_found = 1'b0;
    idx      = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      idx = CW'((32'(last_grant) + k + 1) % N_CH);
      if (!rr_found && nonempty[idx]) begin
        rr_grant = idx;
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    fp_grant = '0;
    fp_found = 1'b0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (!fp_found && nonempty[k]) begin
        fp_grant = CW'(k);
        fp_found = 1'b1;
      end
    end
  end

  always_comb begin
    valid = |nonempty;
    fire  = valid && bus.out_ready;
    if (state == LOCKED)
      grant = lock_grant;
    else
      grant = (ARB_MODE == 1) ? fp_grant : rr_grant;
    head = mem[grant][rd_ptr[grant]];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (valid && !bus.out_ready) state_next = LOCKED;
      LOCKED:  if (bus.out_ready)           state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_grant <= '0;
      last_grant <= CW'(N_CH - 1);
      hold_data  <= '0;
      hold_chan  <= '0;
    end else begin
      if (state == IDLE && valid && !bus.out_ready) lock_grant <= grant;
      if (fire && ARB_MODE == 0)                     last_grant <= grant;
      if (valid) begin
        hold_data <= head;
        hold_chan <= grant;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // Storage carries no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_CH; i++)
      if (push[i]) mem[i][wr_ptr[i]] <= bus.in_data[i*N +: N];
  end

  always_comb begin
    lat_vec = '0;
    lat_sum = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      lat_sum = SW'(count[i]) + SW'(bus.out_latency) + SW'(1);
      lat_vec[i*LW +: LW] = (lat_sum > LAT_MAX) ? LAT_MAX[LW-1:0] : lat_sum[LW-1:0];
    end
  end

  assign bus.in_ready   = ready;
  assign bus.in_latency = lat_vec;
  assign bus.out_valid  = valid;
  assign bus.out_data   = valid ? head  : hold_data;
  assign bus.out_chan   = valid ? grant : hold_chan;
endmodule
